// File: rtl/capture_interface_pkg.sv
// capture_interface_pkg
//   Definitions shared by the camera-side writer and the display-side reader
//   of the frame buffer: FSM state encodings, the RGB565 pixel word type and
//   the default frame geometry.
package capture_interface_pkg;

  // Default frame geometry.
  localparam int unsigned FRAME_H_ACTIVE = 480;
  localparam int unsigned FRAME_V_ACTIVE = 480;
  localparam int unsigned FRAME_ADDR_W   = 18;

  // The display FSM relies on these exact encodings.
  // STATE_DELAY is reserved for the display side.
  typedef enum logic [1:0] {
    STATE_INITIAL = 2'd0,
    STATE_DELAY   = 2'd1,
    STATE_IDLE    = 2'd2,
    STATE_ACTIVE  = 2'd3
  } state_t;

  // RGB565 pixel, stored as {first camera byte, second camera byte}.
  typedef logic [15:0] rgb565_t;

endpackage

// File: rtl/capture_interface_if.sv
// capture_interface_if
//   Parallel camera bus, sampled on the pixel clock.
//   i_vsync : high = vertical blanking
//   i_href  : high = active line bytes
//   i_data  : camera byte
//   master  : camera side (drives the bus)
//   slave   : capture side (samples the bus)
interface capture_interface_if;
  logic       i_vsync;
  logic       i_href;
  logic [7:0] i_data;

  modport master (output i_vsync, i_href, i_data);
  modport slave  (input  i_vsync, i_href, i_data);
endinterface

// File: rtl/capture_interface_pixel_assembler.sv
// capture_interface_pixel_assembler
//   Pairs camera bytes into RGB565 words. The first byte of a pair is latched
//   as the high byte. On the second byte the word is presented together with
//   a one-cycle valid pulse.
//   i_clk   : pixel clock
//   i_rstn  : synchronous active-low reset
//   i_clear : return to phase 0 and drop any latched high byte
//   i_take  : a byte is present on i_byte this cycle
//   i_byte  : camera byte
//   o_valid : combinational pulse, o_word holds a complete pixel
//   o_word  : {latched high byte, current byte}
module capture_interface_pixel_assembler
  import capture_interface_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_clear,
  input  logic       i_take,
  input  logic [7:0] i_byte,
  output logic       o_valid,
  output rgb565_t    o_word
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q,    hi_d;

  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (i_clear) begin
      phase_d = 1'b0;
    end else if (i_take) begin
      if (!phase_q) begin
        hi_d    = i_byte;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
  end

  assign o_valid = i_take & phase_q & ~i_clear;
  assign o_word  = {hi_q, i_byte};

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      phase_q <= 1'b0;
      hi_q    <= '0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

endmodule

// File: rtl/capture_interface.sv
// capture_interface
//   Camera-side frame buffer writer. Samples the camera bus, pairs bytes into
//   RGB565 words and writes them to the frame buffer BRAM. Addresses are
//   derived from row/column so each frame starts at 0 and each line at
//   row*H_ACTIVE, regardless of how many bytes earlier lines carried.
//   i_p_clk : pixel clock, all logic on the rising edge
//   i_rstn  : synchronous active-low reset
//   cam     : camera bus (vsync/href/data), slave side
//   o_wr    : BRAM write strobe, one cycle per pixel
//   o_waddr : BRAM write address
//   o_wdata : RGB565 write data
//   o_sof   : one-cycle pulse, first cycle of a captured frame
//   o_eof   : one-cycle pulse, frame end
module capture_interface
  import capture_interface_pkg::*;
#(
  parameter int unsigned H_ACTIVE = FRAME_H_ACTIVE,
  parameter int unsigned V_ACTIVE = FRAME_V_ACTIVE,
  parameter int unsigned ADDR_W   = FRAME_ADDR_W
) (
  input  logic                      i_p_clk,
  input  logic                      i_rstn,
  capture_interface_if.slave        cam,
  output logic                      o_wr,
  output logic [ADDR_W-1:0]         o_waddr,
  output rgb565_t                   o_wdata,
  output logic                      o_sof,
  output logic                      o_eof
);

  // Counters must be able to hold the saturation values H_ACTIVE / V_ACTIVE.
  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE + 1);

  state_t            state_q, state_d;
  logic              vsync_q, href_q;
  logic [COL_W-1:0]  col_q,   col_d;
  logic [ROW_W-1:0]  row_q,   row_d;
  logic              wr_q,    wr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  rgb565_t           wdata_q, wdata_d;
  logic              sof_q,   sof_d;
  logic              eof_q,   eof_d;

  logic              vsync_rise, vsync_fall, href_fall;
  logic              take, asm_clear, word_valid, in_window;
  rgb565_t           word;
  logic [ADDR_W-1:0] addr_calc;

  assign vsync_rise = cam.i_vsync & ~vsync_q;
  assign vsync_fall = ~cam.i_vsync & vsync_q;
  assign href_fall  = href_q & ~cam.i_href;

  // A vsync rise ends the frame, so a byte arriving on that same edge is dropped.
  assign take = (state_q == STATE_ACTIVE) & cam.i_href & ~vsync_rise;

  assign asm_clear = ((state_q == STATE_IDLE)   & vsync_fall) |
                     ((state_q == STATE_ACTIVE) & (href_fall | vsync_rise));

  capture_interface_pixel_assembler u_asm (
    .i_clk   (i_p_clk),
    .i_rstn  (i_rstn),
    .i_clear (asm_clear),
    .i_take  (take),
    .i_byte  (cam.i_data),
    .o_valid (word_valid),
    .o_word  (word)
  );

  assign in_window = (col_q < COL_W'(H_ACTIVE)) && (row_q < ROW_W'(V_ACTIVE));
  assign addr_calc = ADDR_W'(row_q) * ADDR_W'(H_ACTIVE) + ADDR_W'(col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    sof_d   = 1'b0;
    eof_d   = 1'b0;

    case (state_q)
      STATE_INITIAL: begin
        // Whatever frame was in flight at reset is discarded: wait for blanking.
        if (cam.i_vsync) begin
          state_d = STATE_IDLE;
        end
      end

      STATE_IDLE: begin
        if (vsync_fall) begin
          row_d   = '0;
          col_d   = '0;
          sof_d   = 1'b1;
          state_d = STATE_ACTIVE;
        end
      end

      STATE_ACTIVE: begin
        if (vsync_rise) begin
          eof_d   = 1'b1;
          state_d = STATE_IDLE;
        end else if (href_fall) begin
          col_d = '0;
          if (row_q != ROW_W'(V_ACTIVE)) begin
            row_d = row_q + ROW_W'(1);
          end
        end else if (word_valid) begin
          if (in_window) begin
            wr_d    = 1'b1;
            waddr_d = addr_calc;
            wdata_d = word;
          end
          if (col_q != COL_W'(H_ACTIVE)) begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      default: begin
        state_d = STATE_INITIAL;
      end
    endcase
  end

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      state_q <= STATE_INITIAL;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      wr_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vsync_q <= cam.i_vsync;
      href_q  <= cam.i_href;
      col_q   <= col_d;
      row_q   <= row_d;
      wr_q    <= wr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
    end
  end

  assign o_wr    = wr_q;
  assign o_waddr = waddr_q;
  assign o_wdata = wdata_q;
  assign o_sof   = sof_q;
  assign o_eof   = eof_q;

endmodule
